aer_in_arbiter: RTL and testbench

- Round-robin scheduler that shares the single 10-bit AER input link between NUM_SRC event producers (sorter instances, test pattern source, etc.).
- Picks one pending event and drives the four-phase REQ/ACK handshake toward the neuromorphic core.
- Synchronises the asynchronous ACK, supervises it with a timeout, and keeps a completed-event counter.
- Sits between the sorter-side producers and the off-block AER link, replacing direct producer-to-link wiring.

---
 rtl/aer_pkg.sv | 22 ++
 rtl/aer_sync2.sv | 13 +
 rtl/aer_in_arbiter.sv | 76 +++++++
 tb/tb_aer_in_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aer_pkg.sv
// aer_pkg: shared types, widths and round-robin helper for the AER input arbiter
package aer_pkg;
  localparam int AER_ADDR_W = 10;
  localparam int RR_MAX = 8;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_ACKLOW} aer_arb_state_t;
  function automatic logic [3:0] rr_pick(input logic [RR_MAX-1:0] valid, input logic [2:0] ptr, input int unsigned n);
    logic found;
    logic [2:0] idx;
    logic [2:0] cur;
    found = 1'b0;
    idx = '0;
    cur = ptr;
    for (int unsigned k = 0; k < RR_MAX; k++) begin
      if (k < n && !found && valid[cur]) begin
        found = 1'b1;
        idx = cur;
      end
      cur = (32'(cur) == n - 1) ? 3'd0 : cur + 3'd1;
    end
    return {found, idx};
  endfunction
endpackage

// File: rtl/aer_sync2.sv
// aer_sync2: two-flop synchroniser for asynchronous handshake lines
module aer_sync2 (
  input  logic CLK,
  input  logic RSTN,
  input  logic d,
  output logic q
);
  logic meta;
  // shift the async input through two flops before anyone looks at it
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) {q, meta} <= 2'b00;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/aer_in_arbiter.sv
// aer_in_arbiter: round-robin share of one AER link with four-phase handshake and ACK timeout
module aer_in_arbiter
  import aer_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SRC_BITS = $clog2(NUM_SRC),
  parameter int ADDR_W = AER_ADDR_W,
  parameter int TIMEOUT_CYC = 1023,
  parameter int CNT_W = 16
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  input  logic [NUM_SRC-1:0]        SRC_VALID,
  input  logic [NUM_SRC*ADDR_W-1:0] SRC_ADDR,
  output logic [NUM_SRC-1:0]        SRC_READY,
  output logic [ADDR_W-1:0]         AERIN_ADDR,
  output logic                      AERIN_REQ,
  input  logic                      AERIN_ACK,
  output logic                      BUSY,
  output logic [SRC_BITS-1:0]       LAST_SRC,
  output logic [CNT_W-1:0]          EVT_CNT,
  output logic                      TIMEOUT_ERR,
  input  logic                      CLR
);
  localparam int TW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC > 0 ? TIMEOUT_CYC - 1 : 0);
  aer_arb_state_t state, state_n;
  logic ack_s;
  logic [SRC_BITS-1:0] ptr, grant;
  logic [TW-1:0] timer;
  logic [3:0] pick;
  logic found, fire, tout, done;

  aer_sync2 u_ack_sync (.CLK(CLK), .RSTN(RSTN), .d(AERIN_ACK), .q(ack_s));

  // round-robin pick, handshake progress, timeout detection and next state
  always_comb begin
    pick = rr_pick(8'(SRC_VALID), 3'(ptr), NUM_SRC);
    grant = pick[SRC_BITS-1:0];
    found = pick[3];
    fire = state == ST_IDLE && found && !ack_s;
    done = state == ST_ACKLOW && !ack_s;
    tout = TIMEOUT_CYC != 0 && timer == TMAX && ((state == ST_REQ && !ack_s) || (state == ST_ACKLOW && ack_s));
    state_n = fire ? ST_REQ : (state == ST_REQ && ack_s) ? ST_ACKLOW : (done || tout) ? ST_IDLE : state;
    SRC_READY = (RSTN && fire) ? {{(NUM_SRC-1){1'b0}}, 1'b1} << grant : '0;
  end

  assign BUSY = state != ST_IDLE;

  // FSM state register
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) state <= ST_IDLE;
    else state <= state_n;

  // latch the granted event, run the per-state timer and keep the status counters
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      ptr <= '0;
      timer <= '0;
      AERIN_ADDR <= '0;
      AERIN_REQ <= 1'b0;
      LAST_SRC <= '0;
      EVT_CNT <= '0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      timer <= (state_n != state || state_n == ST_IDLE) ? '0 : timer + 1'b1;
      AERIN_REQ <= state_n == ST_REQ;
      if (fire) begin
        AERIN_ADDR <= SRC_ADDR[grant*ADDR_W +: ADDR_W];
        LAST_SRC <= grant;
        ptr <= (32'(grant) == NUM_SRC - 1) ? '0 : grant + 1'b1;
      end
      EVT_CNT <= CLR ? '0 : (done && !(&EVT_CNT)) ? EVT_CNT + 1'b1 : EVT_CNT;
      TIMEOUT_ERR <= tout || (TIMEOUT_ERR && !CLR);
    end
endmodule

// File: tb/tb_aer_in_arbiter.sv
// tb_aer_in_arbiter: scoreboard bench for the AER input arbiter with a delayed-ACK link model
module tb_aer_in_arbiter;
  logic CLK, RSTN, CLR, AERIN_ACK, AERIN_REQ, BUSY, TIMEOUT_ERR;
  logic [3:0] SRC_VALID, SRC_READY, EVT_CNT;
  logic [39:0] SRC_ADDR;
  logic [9:0] AERIN_ADDR;
  logic [1:0] LAST_SRC;
  int checks = 0;
  int errors = 0;
  logic ack_en;
  int ack_d;
  logic [9:0] src_q[4][$];
  logic [11:0] exp_q[$];
  logic [11:0] pexp;
  logic pend = 1'b0;
  logic [3:0] acc;

  aer_in_arbiter #(.NUM_SRC(4), .TIMEOUT_CYC(16), .CNT_W(4)) dut (
    .CLK(CLK), .RSTN(RSTN), .SRC_VALID(SRC_VALID), .SRC_ADDR(SRC_ADDR), .SRC_READY(SRC_READY),
    .AERIN_ADDR(AERIN_ADDR), .AERIN_REQ(AERIN_REQ), .AERIN_ACK(AERIN_ACK), .BUSY(BUSY),
    .LAST_SRC(LAST_SRC), .EVT_CNT(EVT_CNT), .TIMEOUT_ERR(TIMEOUT_ERR), .CLR(CLR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_req(input string nm, input logic lvl);
    int n = 0;
    while (AERIN_REQ !== lvl && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk(nm, 32'(AERIN_REQ), 32'(lvl));
  endtask

  task automatic wait_ack(input string nm, input logic lvl);
    int n = 0;
    while (AERIN_ACK !== lvl && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk(nm, 32'(AERIN_ACK), 32'(lvl));
  endtask

  task automatic wait_quiet(input string nm);
    int n = 0;
    logic q;
    q = 1'b0;
    while (!q && n < 2000) begin
      @(negedge CLK);
      n++;
      q = exp_q.size() == 0 && !pend && !BUSY && !AERIN_ACK && SRC_VALID == 4'd0 &&
          src_q[0].size() == 0 && src_q[1].size() == 0 && src_q[2].size() == 0 && src_q[3].size() == 0;
    end
    chk(nm, 32'(q), 32'(1));
    repeat (3) @(negedge CLK);
  endtask

  task automatic push_evt(input int s, input logic [9:0] a);
    exp_q.push_back({2'(s), a});
    src_q[s].push_back(a);
  endtask

  task automatic pulse_clr(input string nm);
    @(negedge CLK);
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    chk(nm, 32'(EVT_CNT), 32'(0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, 32'(AERIN_REQ), 32'(0));
    chk({tag, "_addr"}, 32'(AERIN_ADDR), 32'(0));
    chk({tag, "_busy"}, 32'(BUSY), 32'(0));
    chk({tag, "_last"}, 32'(LAST_SRC), 32'(0));
    chk({tag, "_cnt"}, 32'(EVT_CNT), 32'(0));
    chk({tag, "_terr"}, 32'(TIMEOUT_ERR), 32'(0));
    chk({tag, "_ready"}, 32'(SRC_READY), 32'(0));
  endtask

  // producers: each source presents the head of its queue, popped on valid&ready
  initial begin
    SRC_VALID = '0;
    SRC_ADDR = '0;
    forever begin
      @(negedge CLK);
      acc = SRC_VALID & SRC_READY;
      @(posedge CLK);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) void'(src_q[i].pop_front());
        SRC_VALID[i] = src_q[i].size() != 0;
        SRC_ADDR[i*10 +: 10] = src_q[i].size() != 0 ? src_q[i][0] : 10'd0;
      end
    end
  end

  // link model: ACK follows REQ after three cycles when enabled
  initial begin
    AERIN_ACK = 1'b0;
    ack_d = 0;
    forever begin
      @(posedge CLK);
      #2;
      if (ack_en && AERIN_ACK != AERIN_REQ) begin
        ack_d++;
        if (ack_d == 3) begin
          AERIN_ACK = AERIN_REQ;
          ack_d = 0;
        end
      end else ack_d = 0;
    end
  end

  // monitor: every grant pops the scoreboard, the following cycle checks the link
  initial forever begin
    @(negedge CLK);
    if (pend) begin
      chk("link_req", 32'(AERIN_REQ), 32'(1));
      chk("link_addr", 32'(AERIN_ADDR), 32'(pexp[9:0]));
      chk("last_src", 32'(LAST_SRC), 32'(pexp[11:10]));
      pend = 1'b0;
    end
    if (SRC_READY != 4'd0) begin
      chk("ready_while_busy", 32'(BUSY), 32'(0));
      chk("ready_without_valid", 32'(SRC_READY & ~SRC_VALID), 32'(0));
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_grant ready=%b required none", SRC_READY);
      end else begin
        pexp = exp_q.pop_front();
        chk("grant", 32'(SRC_READY), 32'(1) << pexp[11:10]);
        pend = 1'b1;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    RSTN = 1'b0;
    CLR = 1'b0;
    ack_en = 1'b1;
    repeat (3) @(negedge CLK);
    chk_all_zero("reset");
    RSTN = 1'b1;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) push_evt(i, 10'(10'h100 + i * 16 + k));
    wait_quiet("fair_done");
    chk("fair_cnt", 32'(EVT_CNT), 32'(8));
    pulse_clr("clr_cnt");
    push_evt(2, 10'h155);
    wait_req("single_req", 1'b1);
    wait_ack("single_ack", 1'b1);
    n = 0;
    while (AERIN_REQ && n < 20) begin
      n++;
      @(negedge CLK);
    end
    chk("req_fall_lat", 32'(n), 32'(3));
    wait_quiet("single_done");
    chk("single_cnt", 32'(EVT_CNT), 32'(1));
    chk("single_last", 32'(LAST_SRC), 32'(2));
    push_evt(0, 10'h0A0);
    push_evt(1, 10'h0B1);
    wait_quiet("wrap_done");
    chk("wrap_cnt", 32'(EVT_CNT), 32'(3));
    chk("wrap_last", 32'(LAST_SRC), 32'(1));
    ack_en = 1'b0;
    push_evt(3, 10'h3C3);
    wait_req("tout_req", 1'b1);
    n = 0;
    while (AERIN_REQ && n < 100) begin
      n++;
      @(negedge CLK);
    end
    chk("tout_req_cycles", 32'(n), 32'(16));
    chk("tout_err", 32'(TIMEOUT_ERR), 32'(1));
    chk("tout_cnt", 32'(EVT_CNT), 32'(3));
    chk("tout_busy", 32'(BUSY), 32'(0));
    ack_en = 1'b1;
    push_evt(1, 10'h111);
    wait_quiet("after_tout_done");
    chk("after_tout_cnt", 32'(EVT_CNT), 32'(4));
    chk("tout_err_sticky", 32'(TIMEOUT_ERR), 32'(1));
    @(negedge CLK);
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    chk("clr_terr", 32'(TIMEOUT_ERR), 32'(0));
    chk("clr_cnt2", 32'(EVT_CNT), 32'(0));
    push_evt(2, 10'h2A2);
    wait_req("rst_req", 1'b1);
    #2;
    RSTN = 1'b0;
    #1;
    chk_all_zero("midrst");
    repeat (6) @(negedge CLK);
    RSTN = 1'b1;
    push_evt(1, 10'h1B1);
    push_evt(3, 10'h3B3);
    wait_quiet("post_rst_done");
    chk("post_rst_cnt", 32'(EVT_CNT), 32'(2));
    pulse_clr("sat_clr0");
    for (int k = 0; k < 15; k++) push_evt(0, 10'(10'h200 + k));
    wait_quiet("sat15_done");
    chk("sat_cnt15", 32'(EVT_CNT), 32'(15));
    push_evt(0, 10'h21E);
    push_evt(0, 10'h21F);
    wait_quiet("sat17_done");
    chk("sat_cnt17", 32'(EVT_CNT), 32'(15));
    pulse_clr("sat_clr");
    push_evt(0, 10'h301);
    wait_quiet("one_done");
    chk("one_cnt", 32'(EVT_CNT), 32'(1));
    push_evt(0, 10'h302);
    wait_req("coinc_req", 1'b1);
    wait_ack("coinc_ack_hi", 1'b1);
    wait_ack("coinc_ack_lo", 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    chk("coinc_busy", 32'(BUSY), 32'(1));
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    chk("coinc_idle", 32'(BUSY), 32'(0));
    chk("coinc_cnt", 32'(EVT_CNT), 32'(0));
    wait_quiet("final_done");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
